l2_sram_memory_bridge: RTL and testbench
========================================

Name: l2_sram_memory_bridge

Overview:
- Memory-side consumer of the L2 arbiter's memory port. Acts as the slave end of l2_memory_interface.
- Pops one request at a time and executes it as a single-word or burst access against a single-port synchronous SRAM (1-cycle read latency).
- Returns read words tagged with the request id; consumes or discards write data.
- Sits between the L2 arbiter and on-chip backing RAM; replaces an external bus for FPGA/sim builds.

Parameters:
- L2_ID_W, $clog2(L2_NUM_PORTS)+L2_SUB_ID_W: request/response id width; must match the arbiter.
- RAM_ADDR_W, 14: SRAM word-address width. Uses addr[RAM_ADDR_W-1:0]; upper addr bits are ignored.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- addr  in  30  word address of request
- be  in  4  byte enables (single-word writes)
- rnw  in  1  1=read, 0=write
- is_amo  in  1  LR/SC-type access; forces length 1
- amo_type_or_burst_size  in  5  burst length minus 1 when is_amo=0
- id  in  L2_ID_W  request id
- request_valid  in  1  request available
- abort  in  1  qualifies a write request: drop it, discard its data
- request_pop  out  1  request accepted this cycle
- wr_data  in  32  write data word
- wr_data_valid  in  1  write word available
- wr_data_read  out  1  write word consumed this cycle
- rd_data  out  32  read data
- rd_id  out  L2_ID_W  id of read data
- rd_data_valid  out  1  read word valid (no backpressure)
- ram_addr  out  RAM_ADDR_W  SRAM word address
- ram_en  out  1  SRAM access enable
- ram_we  out  4  SRAM byte write enables (0 = read)
- ram_wdata  out  32  SRAM write data
- ram_rdata  in  32  SRAM read data, valid the cycle after a read ram_en

Behaviour:
- Reset state: state=IDLE.
- Reset values, all 0: request_pop, wr_data_read, rd_data_valid, ram_en, ram_we.
- Reset values, 0: rd_id, the counter and the latched fields.
- FSM states: IDLE, READ_BURST, WRITE_BURST, DROP_BURST.
- IDLE, request_valid=1:
  - request_pop=1 combinationally in the same cycle.
  - Latch: addr[RAM_ADDR_W-1:0], id, be, count = is_amo ? 0 : amo_type_or_burst_size.
  - Next state: rnw=1 -> READ_BURST; rnw=0 with abort=0 -> WRITE_BURST; rnw=0 with abort=1 -> DROP_BURST.
- request_pop is asserted only in IDLE. No SRAM access occurs in the pop cycle.
- READ_BURST:
  - Every cycle: ram_en=1, ram_we=0, ram_addr=latched address.
  - Address increments by 1 each cycle, modulo 2^RAM_ADDR_W.
  - Count decrements; on issuing with count=0, return to IDLE.
  - Next request can be popped in the following cycle.
  - Issues exactly count+1 reads on consecutive cycles.
- Read return:
  - 1-stage registered valid/id pipe. rd_data_valid=1 and rd_id=latched id the cycle after each read issue.
  - rd_data = ram_rdata (unregistered).
  - Latency: pop at cycle T, first rd_data_valid at T+2, last at T+2+len-1.
- WRITE_BURST:
  - Cycle with wr_data_valid=1: wr_data_read=1, ram_en=1, ram_wdata=wr_data.
  - ram_we = latched be for a single-word request (len 1); 4'hF for every beat of a burst with len>1.
  - Address increments and count decrements per consumed word; last word -> IDLE.
  - Cycles with wr_data_valid=0: no SRAM access; state and count hold.
- DROP_BURST: wr_data_read=1 on each wr_data_valid; ram_en=0. After count+1 words -> IDLE.
- abort is sampled only in the IDLE pop cycle. It is ignored for reads and in all other states.
- SRAM conflicts are impossible: a single request is active at a time. A read response may overlap the next request's pop cycle.
- Burst length range 1..32; is_amo=1 always gives length 1.
- rst mid-operation:
  - Next cycle: IDLE, counter cleared, rd_data_valid=0.
  - An in-flight read return is dropped.
  - Outstanding write data is not drained; upstream resets together.

Decomposition:
- Add typedef enum l2_sram_bridge_state_t {IDLE, READ_BURST, WRITE_BURST, DROP_BURST} to package l2_config_and_types.
- Width constants L2_NUM_PORTS and L2_SUB_ID_W already come from that package.
- Single module; no sub-module warranted.
- Read return pipe is a few inline registers.

Test Plan:
- Single read: addr=0x10, rnw=1, size=0, id=3; SRAM[0x10]=0xDEADBEEF -> request_pop at T; one rd_data_valid at T+2 with rd_data=0xDEADBEEF, rd_id=3.
- Burst read: addr=0x20, size=7, id=5 -> 8 consecutive rd_data_valid beats (T+2..T+9), data SRAM[0x20..0x27] in order, rd_id=5 each beat.
- Byte write, then full-line write:
  - Single write addr=0x40, be=4'b0010, wr_data=0xAABBCCDD over SRAM=0 -> SRAM[0x40]=0x0000CC00.
  - Burst size=3 with be=4'b0001 -> all 4 words fully written (we=4'hF).
- Write data gaps: burst size=3 with wr_data_valid toggling 1,0,0,1,1,0,1 -> exactly 4 writes to consecutive addresses; FSM returns to IDLE only after the 4th word.
- Abort: write request size=1 with abort=1, then read of the same address -> 2 words consumed (wr_data_read twice), ram_en never high during drop, read returns old contents.
- Edge cases:
  - Burst read at addr=2^RAM_ADDR_W-2, size=3 -> addresses wrap to 0,1.
  - rst asserted 2 cycles into an 8-beat read -> rd_data_valid low from the cycle after rst; next request handled normally.

Source files
------------

// File: rtl/l2_config_and_types.sv
// Shared L2 widths and types for the arbiter and its memory-side consumers.
package l2_config_and_types;

    localparam int L2_NUM_PORTS = 4;
    localparam int L2_SUB_ID_W  = 2;
    localparam int L2_ID_W      = $clog2(L2_NUM_PORTS) + L2_SUB_ID_W;

    typedef logic [L2_ID_W-1:0] l2_id_t;

    typedef enum logic [1:0] {
        IDLE,
        READ_BURST,
        WRITE_BURST,
        DROP_BURST
    } l2_sram_bridge_state_t;

endpackage

// File: rtl/l2_memory_interface.sv
// Request / write-data / read-return bundle between the L2 arbiter and its memory backend.
interface l2_memory_interface;
    import l2_config_and_types::*;

    logic [29:0] addr;
    logic [3:0]  be;
    logic        rnw;
    logic        is_amo;
    logic [4:0]  amo_type_or_burst_size;
    l2_id_t      id;
    logic        request_valid;
    logic        abort;
    logic        request_pop;
    logic [31:0] wr_data;
    logic        wr_data_valid;
    logic        wr_data_read;
    logic [31:0] rd_data;
    l2_id_t      rd_id;
    logic        rd_data_valid;

    modport master (
        output addr, be, rnw, is_amo, amo_type_or_burst_size, id, request_valid, abort,
        output wr_data, wr_data_valid,
        input  request_pop, wr_data_read, rd_data, rd_id, rd_data_valid
    );

    modport slave (
        input  addr, be, rnw, is_amo, amo_type_or_burst_size, id, request_valid, abort,
        input  wr_data, wr_data_valid,
        output request_pop, wr_data_read, rd_data, rd_id, rd_data_valid
    );

endinterface

// File: rtl/l2_sram_memory_bridge.sv
// Executes L2 memory-port requests one at a time against a single-port synchronous SRAM
// (1-cycle read latency), returning id-tagged read words and consuming/discarding write data.
module l2_sram_memory_bridge
    import l2_config_and_types::*;
#(
    parameter int RAM_ADDR_W = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    l2_memory_interface.slave     mem,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    l2_sram_bridge_state_t state_q, state_d;
    logic [RAM_ADDR_W-1:0] addr_q, addr_d;
    l2_id_t                id_q, id_d;
    logic [3:0]            be_q, be_d;
    logic [4:0]            count_q, count_d;
    logic                  single_q, single_d;
    logic                  rd_vld_q, rd_vld_d;
    l2_id_t                rd_id_q, rd_id_d;

    logic       request_pop;
    logic       wr_data_read;
    logic [4:0] req_count;
    logic       last_beat;
    logic       unused_addr_hi;

    assign req_count      = mem.is_amo ? 5'd0 : mem.amo_type_or_burst_size;
    assign last_beat      = (count_q == 5'd0);
    assign unused_addr_hi = ^mem.addr[29:RAM_ADDR_W];

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        id_d         = id_q;
        be_d         = be_q;
        count_d      = count_q;
        single_d     = single_q;
        rd_vld_d     = 1'b0;
        rd_id_d      = rd_id_q;
        request_pop  = 1'b0;
        wr_data_read = 1'b0;
        ram_en       = 1'b0;
        ram_we       = 4'h0;
        ram_addr     = addr_q;
        ram_wdata    = mem.wr_data;

        unique case (state_q)
            IDLE: begin
                if (mem.request_valid) begin
                    request_pop = 1'b1;
                    addr_d      = mem.addr[RAM_ADDR_W-1:0];
                    id_d        = mem.id;
                    be_d        = mem.be;
                    count_d     = req_count;
                    single_d    = (req_count == 5'd0);
                    if (mem.rnw)        state_d = READ_BURST;
                    else if (mem.abort) state_d = DROP_BURST;
                    else                state_d = WRITE_BURST;
                end
            end
            READ_BURST: begin
                ram_en   = 1'b1;
                rd_vld_d = 1'b1;
                rd_id_d  = id_q;
                addr_d   = addr_q + RAM_ADDR_W'(1);
                count_d  = count_q - 5'd1;
                if (last_beat) begin
                    count_d = 5'd0;
                    state_d = IDLE;
                end
            end
            WRITE_BURST: begin
                if (mem.wr_data_valid) begin
                    wr_data_read = 1'b1;
                    ram_en       = 1'b1;
                    // Byte enables only mean something for single-word writes; bursts are full lines.
                    ram_we       = single_q ? be_q : 4'hF;
                    addr_d       = addr_q + RAM_ADDR_W'(1);
                    count_d      = count_q - 5'd1;
                    if (last_beat) begin
                        count_d = 5'd0;
                        state_d = IDLE;
                    end
                end
            end
            DROP_BURST: begin
                if (mem.wr_data_valid) begin
                    wr_data_read = 1'b1;
                    count_d      = count_q - 5'd1;
                    if (last_beat) begin
                        count_d = 5'd0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            id_q     <= '0;
            be_q     <= '0;
            count_q  <= '0;
            single_q <= 1'b0;
            rd_vld_q <= 1'b0;
            rd_id_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            id_q     <= id_d;
            be_q     <= be_d;
            count_q  <= count_d;
            single_q <= single_d;
            rd_vld_q <= rd_vld_d;
            rd_id_q  <= rd_id_d;
        end
    end

    // SRAM output is already registered, so read data passes straight through.
    assign mem.request_pop   = request_pop;
    assign mem.wr_data_read  = wr_data_read;
    assign mem.rd_data       = ram_rdata;
    assign mem.rd_id         = rd_id_q;
    assign mem.rd_data_valid = rd_vld_q;

endmodule

// File: tb/tb_l2_sram_memory_bridge.sv
// Bench for l2_sram_memory_bridge: directed vector table, reset/abort/wrap sequences, random traffic.
module tb_l2_sram_memory_bridge;
  import l2_config_and_types::*;

  localparam int AW   = 14;
  localparam int MASK = (1 << AW) - 1;

  typedef struct {
    logic [29:0] addr;  logic rnw;  logic is_amo;  logic [4:0] size;
    logic [3:0]  be;    l2_id_t id; logic abort;   logic [31:0] vmask;
    logic [31:0] wbase; int exp_len; int exp_en;   int exp_wr;
  } vec_t;

  typedef struct { logic [31:0] data; l2_id_t id; int cyc; } beat_t;

  logic clk = 0, rst = 1;
  logic [AW-1:0] ram_addr;
  logic ram_en;
  logic [3:0] ram_we;
  logic [31:0] ram_wdata, ram_rdata;

  l2_memory_interface bus();

  l2_sram_memory_bridge #(.RAM_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .mem(bus),
    .ram_addr(ram_addr), .ram_en(ram_en), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int a);
    if (a == 'h10) return 32'hDEADBEEF;
    if (a >= 'h20 && a <= 'h27) return 32'h2000_0000 + a;
    if (a == 'h70) return 32'h7070_0000;
    if (a == 'h71) return 32'h7171_0001;
    if (a == 'h3FFE) return 32'h3FFE_3FFE;
    if (a == 'h3FFF) return 32'h3FFF_3FFF;
    if (a == 0) return 32'h0000_1000;
    if (a == 1) return 32'h0000_1001;
    return 32'h0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // SRAM model driven by the DUT's RAM port
  logic [31:0] sram [0:MASK];
  bit inited = 0;
  always @(posedge clk) begin
    if (rst && !inited) begin
      for (int i = 0; i <= MASK; i++) sram[i] <= init_val(i);
      inited <= 1;
    end else if (ram_en) begin
      for (int b = 0; b < 4; b++) if (ram_we[b]) sram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= sram[ram_addr];
    end
  end

  // Reference model state
  logic [31:0] gold [0:MASK];
  beat_t exp_q[$];
  int n_assert = 0, n_fail = 0;
  int cyc = 0, n_beats = 0, n_en = 0, n_wr = 0;
  bit ignore_rd = 0;
  logic [31:0] last_rd = 0;
  beat_t e;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (ram_en) n_en++;
      if (ram_en && ram_we != 0) n_wr++;
      if (bus.rd_data_valid && !ignore_rd) begin
        n_beats++;
        last_rd = bus.rd_data;
        if (exp_q.size() == 0) chk("unexpected rd_data_valid", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("rd_data", bus.rd_data, e.data);
          chk("rd_id", bus.rd_id, e.id);
          chk("rd beat cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic run_req(input vec_t v, input bit drain,
                         output int o_beats, output int o_words, output int o_en, output int o_wr);
    int len, t, k, g, b0, e0, w0, a;
    logic [31:0] wq[$];
    len = v.is_amo ? 1 : int'(v.size) + 1;
    for (int j = 0; j < len; j++) wq.push_back(v.wbase != 0 ? v.wbase + j : $urandom);
    b0 = n_beats; e0 = n_en; w0 = n_wr;
    @(posedge clk); #1;
    bus.addr = v.addr; bus.be = v.be; bus.rnw = v.rnw; bus.is_amo = v.is_amo;
    bus.amo_type_or_burst_size = v.size; bus.id = v.id; bus.abort = v.abort;
    bus.request_valid = 1;
    @(negedge clk);
    chk("request_pop", bus.request_pop, 1);
    g = 0;
    while (!bus.request_pop && g < 64) begin @(posedge clk); #1; @(negedge clk); g++; end
    t = cyc;
    if (v.rnw)
      for (int j = 0; j < len; j++) exp_q.push_back('{gold[(int'(v.addr) + j) & MASK], v.id, t + 2 + j});
    @(posedge clk); #1;
    bus.request_valid = 0; bus.abort = 0;
    k = 0;
    if (v.rnw) begin
      if (drain) begin repeat (len + 1) @(posedge clk); #1; end
      else if (len > 1) begin repeat (len - 1) @(posedge clk); #1; end
    end else begin
      g = 0;
      while (k < len && g < 2000) begin
        bus.wr_data_valid = v.vmask[g % 32];
        bus.wr_data = wq[k];
        @(negedge clk);
        chk("wr_data_read", bus.wr_data_read, bus.wr_data_valid);
        if (bus.wr_data_read && bus.wr_data_valid) k++;
        @(posedge clk); #1;
        g++;
      end
      bus.wr_data_valid = 0;
      chk("write words consumed", k, len);
      if (!v.abort)
        for (int j = 0; j < len; j++) begin
          a = (int'(v.addr) + j) & MASK;
          gold[a] = (len == 1) ? merge(gold[a], wq[j], v.be) : wq[j];
        end
    end
    o_beats = n_beats - b0; o_words = k; o_en = n_en - e0; o_wr = n_wr - w0;
  endtask

  vec_t vecs[15];
  vec_t rv;
  int ob, ow, oe, owr, t0;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i <= MASK; i++) gold[i] = init_val(i);
    bus.addr = 0; bus.be = 0; bus.rnw = 0; bus.is_amo = 0; bus.amo_type_or_burst_size = 0;
    bus.id = 0; bus.request_valid = 0; bus.abort = 0; bus.wr_data = 0; bus.wr_data_valid = 0;

    //          addr         rnw amo size   be      id abort vmask         wbase        len en wr
    vecs[0]  = '{30'h10,      1, 0, 5'd0, 4'h0,   3, 0, 32'hFFFFFFFF, 32'h0,        1, 1, 0};
    vecs[1]  = '{30'h20,      1, 0, 5'd7, 4'h0,   5, 0, 32'hFFFFFFFF, 32'h0,        8, 8, 0};
    vecs[2]  = '{30'h40,      0, 0, 5'd0, 4'b0010,1, 0, 32'hFFFFFFFF, 32'hAABBCCDD, 1, 1, 1};
    vecs[3]  = '{30'h40,      1, 0, 5'd0, 4'h0,   2, 0, 32'hFFFFFFFF, 32'h0,        1, 1, 0};
    vecs[4]  = '{30'h50,      0, 0, 5'd3, 4'b0001,4, 0, 32'hFFFFFFFF, 32'h0,        4, 4, 4};
    vecs[5]  = '{30'h50,      1, 0, 5'd3, 4'h0,   7, 0, 32'hFFFFFFFF, 32'h0,        4, 4, 0};
    vecs[6]  = '{30'h60,      0, 0, 5'd3, 4'h0,   8, 0, 32'h00000059, 32'h0,        4, 4, 4};
    vecs[7]  = '{30'h60,      1, 0, 5'd3, 4'h0,   9, 0, 32'hFFFFFFFF, 32'h0,        4, 4, 0};
    vecs[8]  = '{30'h70,      0, 0, 5'd1, 4'hF,  10, 1, 32'hFFFFFFFF, 32'h0,        2, 0, 0};
    vecs[9]  = '{30'h70,      1, 0, 5'd1, 4'h0,  11, 0, 32'hFFFFFFFF, 32'h0,        2, 2, 0};
    vecs[10] = '{30'h3FFE,    1, 0, 5'd3, 4'h0,  12, 0, 32'hFFFFFFFF, 32'h0,        4, 4, 0};
    vecs[11] = '{30'h20,      1, 1, 5'd5, 4'h0,  13, 0, 32'hFFFFFFFF, 32'h0,        1, 1, 0};
    vecs[12] = '{30'h80,      0, 1, 5'd9, 4'b1100,14, 0, 32'hFFFFFFFF, 32'h12345678, 1, 1, 1};
    vecs[13] = '{30'h80,      1, 0, 5'd0, 4'h0,  15, 0, 32'hFFFFFFFF, 32'h0,        1, 1, 0};
    vecs[14] = '{30'h2000_0010, 1, 0, 5'd0, 4'h0, 6, 1, 32'hFFFFFFFF, 32'h0,        1, 1, 0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset request_pop", bus.request_pop, 0);
    chk("reset wr_data_read", bus.wr_data_read, 0);
    chk("reset rd_data_valid", bus.rd_data_valid, 0);
    chk("reset ram_en", ram_en, 0);
    chk("reset ram_we", ram_we, 0);
    chk("reset rd_id", bus.rd_id, 0);
    @(posedge clk); #1; rst = 0;

    for (int i = 0; i < 15; i++) begin
      run_req(vecs[i], 1, ob, ow, oe, owr);
      if (vecs[i].rnw) chk($sformatf("vec%0d read beats", i), ob, vecs[i].exp_len);
      else             chk($sformatf("vec%0d words consumed", i), ow, vecs[i].exp_len);
      chk($sformatf("vec%0d ram_en cycles", i), oe, vecs[i].exp_en);
      chk($sformatf("vec%0d ram writes", i), owr, vecs[i].exp_wr);
      case (i)
        3:  chk("byte write merge", last_rd, 32'h0000CC00);
        9:  chk("dropped write left old data", last_rd, 32'h7171_0001);
        10: chk("wrapped read last word", last_rd, 32'h0000_1001);
        13: chk("amo write uses be", last_rd, 32'h1234_0000);
        14: chk("upper addr bits ignored", last_rd, 32'hDEADBEEF);
        default: ;
      endcase
    end

    // Reset two cycles into an 8-beat read
    ignore_rd = 1;
    @(posedge clk); #1;
    bus.addr = 30'h20; bus.rnw = 1; bus.is_amo = 0; bus.amo_type_or_burst_size = 7;
    bus.id = 6; bus.request_valid = 1;
    @(negedge clk);
    chk("rst seq pop", bus.request_pop, 1);
    @(posedge clk); #1; bus.request_valid = 0;
    @(posedge clk); #1; rst = 1;
    @(negedge clk);
    chk("rst seq beat in flight", bus.rd_data_valid, 1);
    @(posedge clk); #1; rst = 0;
    repeat (4) begin
      @(negedge clk);
      chk("rd_data_valid after rst", bus.rd_data_valid, 0);
      chk("ram_en after rst", ram_en, 0);
      @(posedge clk); #1;
    end
    exp_q.delete();
    ignore_rd = 0;
    rv = '{30'h24, 1, 0, 5'd1, 4'h0, 2, 0, 32'hFFFFFFFF, 32'h0, 2, 2, 0};
    run_req(rv, 1, ob, ow, oe, owr);
    chk("post-rst read beats", ob, 2);
    chk("post-rst last word", last_rd, 32'h2000_0025);

    // Random traffic, back-to-back when not draining
    for (int n = 0; n < 60; n++) begin
      rv.addr   = ($urandom_range(0, 7) == 0) ? 30'(MASK - $urandom_range(0, 3)) : 30'(32'h100 + $urandom_range(0, 63));
      rv.addr  |= 30'($urandom_range(0, 3)) << 20;
      rv.rnw    = $urandom_range(0, 1);
      rv.is_amo = ($urandom_range(0, 3) == 0);
      rv.size   = 5'($urandom_range(0, 31));
      rv.be     = 4'($urandom);
      rv.id     = l2_id_t'($urandom);
      rv.abort  = ($urandom_range(0, 3) == 0);
      rv.vmask  = $urandom | 32'h1;
      rv.wbase  = 0;
      run_req(rv, $urandom_range(0, 1), ob, ow, oe, owr);
    end
    t0 = 0;
    while (exp_q.size() != 0 && t0 < 100) begin @(posedge clk); t0++; end
    #1;
    chk("all expected read beats returned", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
